// File: rtl/receive_dispatcher.sv
// Inbound packet dispatcher: 2-entry receive FIFO feeding a read/handle/writeback
// sequencer that fetches device state, presents the packet to a handler and commits its update.
module receive_dispatcher #(
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter int PAYLOAD_WIDTH     = 64,
  parameter int STATE_WIDTH       = 128,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  logic                         net_valid,
  output logic                         net_ready,
  input  logic [ADDRESS_MEM_WIDTH-1:0] net_dest,
  input  logic [7:0]                   net_port_id,
  input  logic [7:0]                   net_edge_id,
  input  logic [PAYLOAD_WIDTH-1:0]     net_payload,
  output logic [PAYLOAD_WIDTH-1:0]     packet_in,
  output logic                         packet_in_valid,
  output logic                         receive_done,
  output logic [7:0]                   edge_id,
  output logic [7:0]                   port_id,
  input  logic                         packet_handled,
  output logic                         state_rd_en,
  input  logic [STATE_WIDTH-1:0]       state_rd_data,
  output logic [STATE_WIDTH-1:0]       read_state,
  input  logic [STATE_WIDTH-1:0]       write_state,
  input  logic                         write_state_valid,
  output logic                         state_wr_en,
  output logic [STATE_WIDTH-1:0]       state_wr_data,
  output logic [15:0]                  drop_count,
  output logic                         timeout_err
);

  localparam int PKT_W = PAYLOAD_WIDTH + 16;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_READ      = 2'd1;
  localparam logic [1:0] S_HANDLE    = 2'd2;
  localparam logic [1:0] S_WRITEBACK = 2'd3;

  logic [PKT_W-1:0]       fifo_q [2];
  logic                   wptr_q, wptr_d;
  logic                   rptr_q, rptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [15:0]            drop_q, drop_d;

  logic [1:0]             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [PKT_W-1:0]       hold_q, hold_d;
  logic [STATE_WIDTH-1:0] rstate_q, rstate_d;
  logic [STATE_WIDTH-1:0] wdata_q, wdata_d;
  logic                   wpend_q, wpend_d;
  logic                   tout_q, tout_d;

  logic accept, push, drop, pop;

  // Packets for other addresses are consumed from the network but never stored
  assign net_ready = (cnt_q != 2'd2);
  assign accept    = net_valid & net_ready;
  assign push      = accept & (net_dest == address);
  assign drop      = accept & (net_dest != address);
  assign pop       = (state_q == S_IDLE) & (cnt_q != 2'd0);

  always_comb begin
    wptr_d = push ? ~wptr_q : wptr_q;
    rptr_d = pop  ? ~rptr_q : rptr_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {net_port_id, net_edge_id, net_payload};
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    hold_d   = hold_q;
    rstate_d = rstate_q;
    wdata_d  = wdata_q;
    wpend_d  = wpend_q;
    tout_d   = tout_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          hold_d  = fifo_q[rptr_q];
          state_d = S_READ;
        end
      end
      S_READ: begin
        rstate_d = state_rd_data;
        timer_d  = '0;
        wpend_d  = 1'b0;
        state_d  = S_HANDLE;
      end
      S_HANDLE: begin
        if (packet_handled) begin
          state_d = S_WRITEBACK;
          if (write_state_valid) begin
            wpend_d = 1'b1;
            wdata_d = write_state;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        wpend_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
      drop_q   <= 16'd0;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      hold_q   <= '0;
      rstate_q <= '0;
      wdata_q  <= '0;
      wpend_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      hold_q   <= hold_d;
      rstate_q <= rstate_d;
      wdata_q  <= wdata_d;
      wpend_q  <= wpend_d;
      tout_q   <= tout_d;
    end
  end

  // The packet stays presented through writeback and drops on return to idle
  assign state_rd_en     = pop;
  assign packet_in       = hold_q[PAYLOAD_WIDTH-1:0];
  assign edge_id         = hold_q[PAYLOAD_WIDTH+7:PAYLOAD_WIDTH];
  assign port_id         = hold_q[PAYLOAD_WIDTH+15:PAYLOAD_WIDTH+8];
  assign packet_in_valid = (state_q == S_HANDLE) | (state_q == S_WRITEBACK);
  assign receive_done    = (state_q == S_HANDLE) & (timer_q == '0);
  assign read_state      = rstate_q;
  assign state_wr_en     = (state_q == S_WRITEBACK) & wpend_q;
  assign state_wr_data   = wdata_q;
  assign drop_count      = drop_q;
  assign timeout_err     = tout_q;

endmodule
